// File: rtl/ulbf_coeffs_csr_mc_pkg.sv
// Package ulbf_csr_pkg: CSR offsets, identification constant, CTRL bit
// positions and done-counter width shared by the CSR top and the per-channel
// done tracker.
package ulbf_csr_pkg;

  localparam logic [7:0] OFS_ID          = 8'h00;
  localparam logic [7:0] OFS_CTRL        = 8'h04;
  localparam logic [7:0] OFS_BLOCK_SIZE  = 8'h08;
  localparam logic [7:0] OFS_NITER       = 8'h0C;
  localparam logic [7:0] OFS_ROLLOVER    = 8'h10;
  localparam logic [7:0] OFS_IRQ_EN      = 8'h14;
  localparam logic [7:0] OFS_NUM_CH      = 8'h18;
  localparam logic [7:0] OFS_DONE_STICKY = 8'h20;
  localparam logic [7:0] OFS_DONE_RAW    = 8'h24;
  localparam logic [7:0] OFS_ROW_BASE    = 8'h40;
  localparam logic [7:0] OFS_CNT_BASE    = 8'h80;

  localparam logic [31:0] CSR_ID = 32'h0123_4567;

  localparam int unsigned CTRL_RST_BIT      = 0;
  localparam int unsigned CTRL_GO_BIT       = 4;
  localparam int unsigned CTRL_PULSE_BIT    = 8;
  localparam int unsigned CTRL_CLR_CNT_BIT  = 9;
  localparam int unsigned CTRL_CLR_DONE_BIT = 12;

  localparam int unsigned CNT_W = 16;

  // Write-only CTRL strobes decoded from a single CTRL write.
  typedef struct packed {
    logic pulse;
    logic clr_cnt;
    logic clr_done;
  } ctrl_strobe_t;

  // Offset of per-channel register ch inside a 4-byte-stride window.
  function automatic logic [7:0] ch_ofs(input logic [7:0] base, input int unsigned ch);
    return base + 8'(ch * 4);
  endfunction

endpackage

// File: rtl/ulbf_coeffs_csr_mc_done_tracker.sv
// ulbf_done_tracker: one channel's done bookkeeping.
//  clk, rst_n   : clock, asynchronous active-low reset
//  done         : channel done level
//  clr_sticky   : clear request for the sticky flag (a same-cycle rise wins)
//  clr_cnt      : zero the counter (wins over a same-cycle rise)
//  sticky       : set on every rising edge of done
//  cnt          : saturating count of rising edges
module ulbf_done_tracker
  import ulbf_csr_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             done,
  input  logic             clr_sticky,
  input  logic             clr_cnt,
  output logic             sticky,
  output logic [CNT_W-1:0] cnt
);

  logic d_prev;
  logic rise;

  // d_prev resets to 0, so a level already high at reset release is a rise.
  assign rise = done & ~d_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_prev <= 1'b0;
      sticky <= 1'b0;
      cnt    <= '0;
    end else begin
      d_prev <= done;
      if (rise)            sticky <= 1'b1;
      else if (clr_sticky) sticky <= 1'b0;
      if (clr_cnt)                cnt <= '0;
      else if (rise && cnt != '1) cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/ulbf_coeffs_csr_mc.sv
// ulbf_coeffs_csr_mc: CSR block for the ulbf coeffs PL datapath.
//  BRAM_PORTA_*  : CSR access port (addr bit19 selects the CSR window, [7:0] offset)
//  m_done        : per-channel done levels
//  addrb_wire    : per-channel RAM row addresses, read back through ROW_i
//  go/m_axis_rst : CTRL level bits; go_pulse: one-cycle start strobe
//  block_size/niter/rollover_addr : low bits of the matching registers
//  irq           : registered OR of enabled sticky done flags
//  csr_rddata    : registered read data, holds between reads
module ulbf_coeffs_csr_mc
  import ulbf_csr_pkg::*;
#(
  parameter int unsigned NUM_CH         = 8,
  parameter int unsigned ROW_W          = 16,
  parameter int unsigned BLK_W          = 12,
  parameter logic [31:0] DEF_BLOCK_SIZE = 32'd256,
  parameter logic [31:0] DEF_NITER      = 32'd4,
  parameter logic [31:0] DEF_ROLLOVER   = 32'd1024
) (
  input  logic                    BRAM_PORTA_clk,
  input  logic                    BRAM_PORTA_rstn,
  input  logic [19:0]             BRAM_PORTA_addr,
  input  logic [31:0]             BRAM_PORTA_din,
  input  logic                    BRAM_PORTA_en,
  input  logic                    BRAM_PORTA_we,
  input  logic [NUM_CH-1:0]       m_done,
  input  logic [NUM_CH*ROW_W-1:0] addrb_wire,
  output logic                    go,
  output logic                    go_pulse,
  output logic                    m_axis_rst,
  output logic [BLK_W-1:0]        block_size,
  output logic [BLK_W-1:0]        niter,
  output logic [ROW_W-1:0]        rollover_addr,
  output logic                    irq,
  output logic [31:0]             csr_rddata
);

  logic [7:0]  ofs;
  logic        wr, rd, ctrl_wr;
  logic        unused_addr_bits;

  logic        ctrl_rst, ctrl_go, go_pulse_q, irq_q;
  logic [31:0] block_size_q, niter_q, rollover_q, rddata_q, rd_mux;
  logic [NUM_CH-1:0] irq_en, sticky, clr_sticky;
  logic [CNT_W-1:0]  cnt [NUM_CH];
  ctrl_strobe_t      stb;

  assign ofs              = BRAM_PORTA_addr[7:0];
  assign wr               = BRAM_PORTA_en & BRAM_PORTA_addr[19] & BRAM_PORTA_we;
  assign rd               = BRAM_PORTA_en & BRAM_PORTA_addr[19] & ~BRAM_PORTA_we;
  assign ctrl_wr          = wr && (ofs == OFS_CTRL);
  assign unused_addr_bits = ^BRAM_PORTA_addr[18:8];

  always_comb begin
    stb          = '0;
    stb.pulse    = ctrl_wr & BRAM_PORTA_din[CTRL_PULSE_BIT];
    stb.clr_cnt  = ctrl_wr & BRAM_PORTA_din[CTRL_CLR_CNT_BIT];
    stb.clr_done = stb.pulse & BRAM_PORTA_din[CTRL_CLR_DONE_BIT];
  end

  // W1C mask from a DONE_STICKY write, or a clear-all from go with clr_done_on_go.
  always_comb begin
    clr_sticky = {NUM_CH{stb.clr_done}};
    if (wr && (ofs == OFS_DONE_STICKY))
      clr_sticky = clr_sticky | BRAM_PORTA_din[NUM_CH-1:0];
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    ulbf_done_tracker u_trk (
      .clk        (BRAM_PORTA_clk),
      .rst_n      (BRAM_PORTA_rstn),
      .done       (m_done[i]),
      .clr_sticky (clr_sticky[i]),
      .clr_cnt    (stb.clr_cnt),
      .sticky     (sticky[i]),
      .cnt        (cnt[i])
    );
  end

  // Read mux sees pre-update register values, so a DONE_STICKY read returns
  // the flags as they were before any same-cycle set/clear.
  always_comb begin
    rd_mux = '0;
    case (ofs)
      OFS_ID:          rd_mux = CSR_ID;
      OFS_CTRL: begin
        rd_mux[CTRL_RST_BIT] = ctrl_rst;
        rd_mux[CTRL_GO_BIT]  = ctrl_go;
      end
      OFS_BLOCK_SIZE:  rd_mux = block_size_q;
      OFS_NITER:       rd_mux = niter_q;
      OFS_ROLLOVER:    rd_mux = rollover_q;
      OFS_IRQ_EN:      rd_mux[NUM_CH-1:0] = irq_en;
      OFS_NUM_CH:      rd_mux = 32'(NUM_CH);
      OFS_DONE_STICKY: rd_mux[NUM_CH-1:0] = sticky;
      OFS_DONE_RAW:    rd_mux[NUM_CH-1:0] = m_done;
      default:         ;
    endcase
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (ofs == ch_ofs(OFS_ROW_BASE, i)) rd_mux = 32'(addrb_wire[i*ROW_W +: ROW_W]);
      if (ofs == ch_ofs(OFS_CNT_BASE, i)) rd_mux = 32'(cnt[i]);
    end
  end

  always_ff @(posedge BRAM_PORTA_clk or negedge BRAM_PORTA_rstn) begin
    if (!BRAM_PORTA_rstn) begin
      ctrl_rst     <= 1'b0;
      ctrl_go      <= 1'b0;
      block_size_q <= DEF_BLOCK_SIZE;
      niter_q      <= DEF_NITER;
      rollover_q   <= DEF_ROLLOVER;
      irq_en       <= '0;
      go_pulse_q   <= 1'b0;
      irq_q        <= 1'b0;
      rddata_q     <= '0;
    end else begin
      go_pulse_q <= stb.pulse;
      irq_q      <= |(sticky & irq_en);
      if (wr) begin
        case (ofs)
          OFS_CTRL: begin
            ctrl_rst <= BRAM_PORTA_din[CTRL_RST_BIT];
            ctrl_go  <= BRAM_PORTA_din[CTRL_GO_BIT];
          end
          OFS_BLOCK_SIZE: block_size_q <= BRAM_PORTA_din;
          OFS_NITER:      niter_q      <= BRAM_PORTA_din;
          OFS_ROLLOVER:   rollover_q   <= BRAM_PORTA_din;
          OFS_IRQ_EN:     irq_en       <= BRAM_PORTA_din[NUM_CH-1:0];
          default:        ;
        endcase
      end
      if (rd) rddata_q <= rd_mux;
    end
  end

  assign go            = ctrl_go;
  assign go_pulse      = go_pulse_q;
  assign m_axis_rst    = ctrl_rst;
  assign block_size    = block_size_q[BLK_W-1:0];
  assign niter         = niter_q[BLK_W-1:0];
  assign rollover_addr = rollover_q[ROW_W-1:0];
  assign irq           = irq_q;
  assign csr_rddata    = rddata_q;

endmodule

// File: tb/tb_ulbf_coeffs_csr_mc.sv
module tb_ulbf_coeffs_csr_mc;
  localparam int NUM_CH = 8;
  localparam int ROW_W  = 16;
  localparam int BLK_W  = 12;

  logic                    clk = 1'b0;
  logic                    rstn = 1'b0;
  logic [19:0]             addr = '0;
  logic [31:0]             din = '0;
  logic                    en = 1'b0;
  logic                    we = 1'b0;
  logic [NUM_CH-1:0]       done = '0;
  logic [NUM_CH*ROW_W-1:0] addrb = '0;
  logic                    go, go_pulse, m_axis_rst, irq;
  logic [BLK_W-1:0]        block_size, niter;
  logic [ROW_W-1:0]        rollover_addr;
  logic [31:0]             csr_rddata;

  always #5 clk = ~clk;

  ulbf_coeffs_csr_mc #(
    .NUM_CH(NUM_CH), .ROW_W(ROW_W), .BLK_W(BLK_W),
    .DEF_BLOCK_SIZE(32'd256), .DEF_NITER(32'd4), .DEF_ROLLOVER(32'd1024)
  ) dut (
    .BRAM_PORTA_clk(clk), .BRAM_PORTA_rstn(rstn), .BRAM_PORTA_addr(addr),
    .BRAM_PORTA_din(din), .BRAM_PORTA_en(en), .BRAM_PORTA_we(we),
    .m_done(done), .addrb_wire(addrb), .go(go), .go_pulse(go_pulse),
    .m_axis_rst(m_axis_rst), .block_size(block_size), .niter(niter),
    .rollover_addr(rollover_addr), .irq(irq), .csr_rddata(csr_rddata)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_on   = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (register-map view) ----------------
  bit          m_rst, m_go, m_pulse, m_irq;
  bit [31:0]   m_blk, m_nit, m_roll, m_irqen, m_sticky, m_rd;
  int unsigned m_cnt [NUM_CH];
  bit [NUM_CH-1:0] m_prev;
  localparam bit [31:0] CH_MASK = (32'd1 << NUM_CH) - 32'd1;

  task automatic model_reset();
    m_rst = 0; m_go = 0; m_pulse = 0; m_irq = 0;
    m_blk = 256; m_nit = 4; m_roll = 1024;
    m_irqen = 0; m_sticky = 0; m_rd = 0; m_prev = '0;
    for (int i = 0; i < NUM_CH; i++) m_cnt[i] = 0;
  endtask

  function automatic bit [31:0] model_read(input bit [7:0] o);
    int oi = int'(o);
    if (oi % 4 == 0 && oi >= 'h40 && oi < 'h40 + 4*NUM_CH) begin
      int idx = (oi - 'h40) / 4;
      return 32'(addrb[idx*ROW_W +: ROW_W]);
    end
    if (oi % 4 == 0 && oi >= 'h80 && oi < 'h80 + 4*NUM_CH)
      return m_cnt[(oi - 'h80) / 4];
    case (oi)
      'h00: return 32'h0123_4567;
      'h04: return {27'd0, m_go, 3'd0, m_rst};
      'h08: return m_blk;
      'h0C: return m_nit;
      'h10: return m_roll;
      'h14: return m_irqen;
      'h18: return NUM_CH;
      'h20: return m_sticky;
      'h24: return 32'(done);
      default: return 0;
    endcase
  endfunction

  // One clock edge worth of register-map behaviour, from the inputs as sampled.
  task automatic model_clock();
    bit        sel   = en && addr[19];
    bit        w     = sel && we;
    bit [7:0]  o     = addr[7:0];
    bit        ctrlw = w && (o == 8'h04);
    bit [31:0] rise  = 32'(done & ~m_prev);
    bit [31:0] clr   = 0;
    bit        nirq  = |(m_sticky & m_irqen);
    if (sel && !we) m_rd = model_read(o);
    if (w && o == 8'h20) clr = din;
    if (ctrlw && din[8] && din[12]) clr = '1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ctrlw && din[9]) m_cnt[i] = 0;
      else if (rise[i] && m_cnt[i] < 65535) m_cnt[i] = m_cnt[i] + 1;
    end
    m_sticky = ((m_sticky & ~clr) | rise) & CH_MASK;
    m_pulse  = ctrlw && din[8];
    if (w) begin
      case (o)
        8'h04: begin m_rst = din[0]; m_go = din[4]; end
        8'h08: m_blk = din;
        8'h0C: m_nit = din;
        8'h10: m_roll = din;
        8'h14: m_irqen = din & CH_MASK;
        default: ;
      endcase
    end
    m_prev = done;
    m_irq  = nirq;
  endtask

  task automatic check_outputs();
    if (!chk_on) return;
    check("go", go, m_go);
    check("go_pulse", go_pulse, m_pulse);
    check("m_axis_rst", m_axis_rst, m_rst);
    check("block_size", block_size, m_blk[BLK_W-1:0]);
    check("niter", niter, m_nit[BLK_W-1:0]);
    check("rollover_addr", rollover_addr, m_roll[ROW_W-1:0]);
    check("irq", irq, m_irq);
    check("csr_rddata", csr_rddata, m_rd);
  endtask

  task automatic tick();
    @(posedge clk);
    model_clock();
    #1;
    check_outputs();
  endtask

  function automatic logic [19:0] csr(input bit [7:0] o);
    return {1'b1, 11'd0, o};
  endfunction

  task automatic wr(input bit [7:0] o, input bit [31:0] d);
    en = 1; we = 1; addr = csr(o); din = d;
    tick();
    en = 0; we = 0;
  endtask

  task automatic rd(input bit [7:0] o, output bit [31:0] d);
    en = 1; we = 0; addr = csr(o);
    tick();
    en = 0;
    d = csr_rddata;
  endtask

  typedef struct {
    bit [7:0]  ofs;
    bit [31:0] exp;
  } rd_vec_t;

  rd_vec_t tbl [15];

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit [31:0] v;
    bit [7:0]  offs [16] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h20,
                             8'h24, 8'h40, 8'h5C, 8'h80, 8'h9C, 8'hA0, 8'h02, 8'h30};

    for (int i = 0; i < NUM_CH; i++) addrb[i*ROW_W +: ROW_W] = 16'hA000 | 16'(i);

    tbl[0]  = '{8'h00, 32'h0123_4567};
    tbl[1]  = '{8'h04, 32'h0};
    tbl[2]  = '{8'h08, 32'd256};
    tbl[3]  = '{8'h0C, 32'd4};
    tbl[4]  = '{8'h10, 32'd1024};
    tbl[5]  = '{8'h14, 32'h0};
    tbl[6]  = '{8'h18, 32'd8};
    tbl[7]  = '{8'h20, 32'h0};
    tbl[8]  = '{8'h24, 32'h0};
    tbl[9]  = '{8'h44, 32'h0000_A001};
    tbl[10] = '{8'h5C, 32'h0000_A007};
    tbl[11] = '{8'h60, 32'h0};
    tbl[12] = '{8'h84, 32'h0};
    tbl[13] = '{8'h30, 32'h0};
    tbl[14] = '{8'h02, 32'h0};

    // reset
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    check("rst_go", go, 0);
    check("rst_m_axis_rst", m_axis_rst, 0);
    check("rst_go_pulse", go_pulse, 0);
    check("rst_block_size", block_size, 256);
    check("rst_niter", niter, 4);
    check("rst_rollover", rollover_addr, 1024);
    check("rst_irq", irq, 0);
    check("rst_rddata", csr_rddata, 0);
    rstn = 1;

    // register map after reset, table-driven
    foreach (tbl[i]) begin
      rd(tbl[i].ofs, v);
      check($sformatf("tbl_rd_%02h", tbl[i].ofs), v, tbl[i].exp);
    end

    // non-CSR accesses change nothing, rddata holds
    en = 1; we = 1; addr = 20'h0_0008; din = 32'h77; tick();
    we = 0; tick(); en = 0;
    check("noncsr_block_size", block_size, 256);
    check("noncsr_rd_hold", csr_rddata, 32'h0);

    // CTRL write with go_pulse
    en = 1; we = 1; addr = csr(8'h04); din = 32'h111;
    tick(); en = 0; we = 0;
    check("ctrl_go", go, 1);
    check("ctrl_m_axis_rst", m_axis_rst, 1);
    check("go_pulse_first", go_pulse, 1);
    tick();
    check("go_pulse_one_cycle", go_pulse, 0);
    rd(8'h04, v);
    check("ctrl_readback", v, 32'h11);
    en = 1; we = 1; addr = csr(8'h04); din = 32'h110;
    tick(); check("b2b_pulse_1", go_pulse, 1);
    tick(); check("b2b_pulse_2", go_pulse, 1);
    en = 0; we = 0;
    tick(); check("b2b_pulse_end", go_pulse, 0);

    // done edges: ch3 pulsed twice, ch5 held
    done[5] = 1; done[3] = 1; tick();
    done[3] = 0; tick();
    done[3] = 1; tick();
    done[3] = 0; tick();
    rd(8'h20, v); check("sticky_28", v, 32'h28);
    rd(8'h8C, v); check("cnt3_2", v, 2);
    rd(8'h94, v); check("cnt5_1", v, 1);
    rd(8'h24, v); check("raw_bit5", v, 32'h20);

    // irq and W1C vs same-cycle rise
    wr(8'h20, 32'hFF);
    wr(8'h14, 32'h08);
    tick(); check("irq_idle", irq, 0);
    done[3] = 1; tick();
    tick(); check("irq_set", irq, 1);
    done[3] = 0; tick();
    done[3] = 1; wr(8'h20, 32'h08);
    done[3] = 0;
    rd(8'h20, v); check("w1c_rise_wins", v, 32'h08);
    check("irq_held", irq, 1);
    wr(8'h20, 32'h08);
    tick(); check("irq_clear", irq, 0);

    // clr_done_on_go only together with go_pulse; same-cycle rise survives
    done[1] = 1; tick(); done[1] = 0; tick();
    wr(8'h04, 32'h1000);
    rd(8'h20, v); check("clrgo_needs_pulse", v, 32'h02);
    done[2] = 1; wr(8'h04, 32'h1100); done[2] = 0;
    rd(8'h20, v); check("clrgo_rise_wins", v, 32'h04);

    // counter saturation on ch0
    chk_on = 0;
    for (int k = 0; k < 65540; k++) begin
      done[0] = 1; tick();
      done[0] = 0; tick();
    end
    chk_on = 1;
    rd(8'h80, v); check("cnt0_saturated", v, 32'hFFFF);
    done[1] = 1; wr(8'h04, 32'h200); done[1] = 0;
    rd(8'h80, v); check("cnt0_cleared", v, 0);
    rd(8'h84, v); check("cnt1_clear_wins", v, 0);
    done[1] = 1; tick(); done[1] = 0;
    rd(8'h84, v); check("cnt1_restart", v, 1);

    // randomized traffic against the model
    for (int k = 0; k < 800; k++) begin
      en   = ($urandom_range(0, 3) != 0);
      we   = $urandom_range(0, 1);
      addr = {($urandom_range(0, 7) != 0), 11'($urandom), offs[$urandom_range(0, 15)]};
      if ($urandom_range(0, 9) == 0) addr[7:0] = 8'($urandom);
      din  = $urandom;
      done = done ^ (NUM_CH'($urandom) & NUM_CH'($urandom));
      if ($urandom_range(0, 31) == 0) addrb = {$urandom, $urandom, $urandom, $urandom};
      tick();
    end
    en = 0; we = 0;

    // asynchronous reset in the middle of a write
    wr(8'h04, 32'h10);
    check("pre_rst_go", go, 1);
    done = 8'h60;
    tick();
    en = 1; we = 1; addr = csr(8'h08); din = 32'h55;
    #2 rstn = 0;
    #1;
    check("arst_go", go, 0);
    check("arst_m_axis_rst", m_axis_rst, 0);
    check("arst_go_pulse", go_pulse, 0);
    check("arst_block_size", block_size, 256);
    check("arst_niter", niter, 4);
    check("arst_rollover", rollover_addr, 1024);
    check("arst_irq", irq, 0);
    check("arst_rddata", csr_rddata, 0);
    model_reset();
    @(posedge clk); #1;
    en = 0; we = 0;
    rstn = 1;
    rd(8'h20, v); check("post_rst_sticky_pre", v, 0);
    rd(8'h20, v); check("post_rst_sticky_rise", v, 32'h60);
    rd(8'h08, v); check("post_rst_write_lost", v, 256);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
